// File: rtl/cache_line_xfer.sv
// -----------------------------------------------------------------------------
// cache_line_xfer
//
// Moves one cache line between the data-cache array and main memory, one word
// per cycle. Two directions are supported:
//   mode = 0 : writeback (cache -> memory), used for dirty-line eviction
//   mode = 1 : refill    (memory -> cache), used on a miss
// Both RAMs are synchronous with a read latency of RD_LAT cycles. The engine
// issues WORDS_PER_LINE source reads back to back and writes each returned word
// into the destination exactly RD_LAT cycles after its read was issued.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start         request pulse, only honoured in IDLE
//   mode          transfer direction (see above), latched with start
//   line_addr     CPU byte address of the line, latched with start
//   busy          high while reading or draining the read pipeline
//   done          single-cycle pulse once the last destination write is done
//   cache_addr    cache word address {index, word}
//   cache_we      cache write enable (refill only)
//   cache_din     cache write data, wired straight from mem_dout
//   cache_dout    cache read data
//   mem_addr      main-memory word address
//   mem_we        memory write enable (writeback only)
//   mem_din       memory write data, wired straight from cache_dout
//   mem_dout      memory read data
//
// All outputs except the two data buses are registered. The address bus of a
// RAM that is neither being read nor written in a cycle is driven to zero.
// -----------------------------------------------------------------------------
module cache_line_xfer #(
    parameter int WORDS_PER_LINE = 8,
    parameter int INDEX_W        = 6,
    parameter int ADDR_W         = 32,
    parameter int MEM_ADDR_W     = 13,
    parameter int RD_LAT         = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        mode,
    input  logic [ADDR_W-1:0]                           line_addr,
    output logic                                        busy,
    output logic                                        done,
    output logic [INDEX_W+$clog2(WORDS_PER_LINE)-1:0]   cache_addr,
    output logic                                        cache_we,
    output logic [31:0]                                 cache_din,
    input  logic [31:0]                                 cache_dout,
    output logic [MEM_ADDR_W-1:0]                       mem_addr,
    output logic                                        mem_we,
    output logic [31:0]                                 mem_din,
    input  logic [31:0]                                 mem_dout
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int CA_W   = INDEX_W + OFF_W;
    // Drain counter only needs to reach RD_LAT-1 (at most 3).
    localparam int DCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e                          state_q, state_d;
    logic                            mode_q, mode_d;
    logic [INDEX_W-1:0]              index_q, index_d;
    logic [MEM_ADDR_W-1:0]           base_q, base_d;
    logic [OFF_W-1:0]                rd_k_q, rd_k_d;
    logic [DCNT_W-1:0]               drain_q, drain_d;

    // Read-tracking pipeline: entry 0 describes the read presented in the
    // current cycle, entry i the read presented i cycles ago.
    logic [RD_LAT-1:0]               pv_q, pv_d;
    logic [RD_LAT-1:0][OFF_W-1:0]    pk_q, pk_d;

    // Registered outputs
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [CA_W-1:0]                 cache_addr_q, cache_addr_d;
    logic                            cache_we_q, cache_we_d;
    logic [MEM_ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic                            mem_we_q, mem_we_d;

    // Read issued in the next cycle (valid flag and word offset)
    logic                            rd_issue_s;
    // Write performed in the next cycle (oldest pipeline entry)
    logic                            wr_valid_s;
    logic [OFF_W-1:0]                wr_k_s;

    // ---------------------------------------------------------------------
    // Address field extraction from the requested line
    // ---------------------------------------------------------------------
    logic [INDEX_W-1:0]              line_index_s;
    logic [ADDR_W-3:0]               line_word_s;
    logic [MEM_ADDR_W-1:0]           line_base_s;
    logic                            unused_addr_bits_s;

    assign line_index_s = line_addr[OFF_W+2+INDEX_W-1 : OFF_W+2];
    // Word address of word 0 of the line: {tag-line, OFF_W zeros}.
    assign line_word_s  = {line_addr[ADDR_W-1:OFF_W+2], {OFF_W{1'b0}}};
    // Main memory is smaller than the CPU space; upper bits are dropped.
    assign line_base_s  = line_word_s[MEM_ADDR_W-1:0];
    assign unused_addr_bits_s = ^{line_addr[OFF_W+1:0], line_word_s[ADDR_W-3:MEM_ADDR_W]};

    // Data paths are pure wires: the destination captures the source dout
    // in the same cycle the write strobe is high.
    assign cache_din = mem_dout;
    assign mem_din   = cache_dout;

    assign busy       = busy_q;
    assign done       = done_q;
    assign cache_addr = cache_addr_q;
    assign cache_we   = cache_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;

    // Next-state logic for the transfer FSM and its latched request fields.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        index_d    = index_q;
        base_d     = base_q;
        rd_k_d     = rd_k_q;
        drain_d    = drain_q;
        rd_issue_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_XFER;
                    mode_d     = mode;
                    index_d    = line_index_s;
                    base_d     = line_base_s;
                    rd_k_d     = {OFF_W{1'b0}};
                    rd_issue_s = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_XFER: begin
                // rd_k_q is the word being read in this cycle.
                if (rd_k_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = {DCNT_W{1'b0}};
                end else begin
                    rd_k_d     = rd_k_q + OFF_W'(1);
                    rd_issue_s = 1'b1;
                end
            end
            S_DRAIN: begin
                // Wait for the last read to come back and be written.
                if (drain_q == DCNT_W'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DCNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read-tracking pipeline shift and next values of the registered outputs.
    always_comb begin
        pv_d         = {pv_q[RD_LAT-1:0], rd_issue_s};
        pk_d         = pk_q;
        cache_addr_d = {CA_W{1'b0}};
        mem_addr_d   = {MEM_ADDR_W{1'b0}};
        cache_we_d   = 1'b0;
        mem_we_d     = 1'b0;

        pv_d[0] = rd_issue_s;
        pk_d[0] = rd_k_d;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pk_d[i] = pk_q[i-1];
        end

        // The entry that is RD_LAT-1 cycles old now is RD_LAT cycles old
        // next cycle, so its data is on the source dout next cycle.
        wr_valid_s = pv_q[RD_LAT-1];
        wr_k_s     = pk_q[RD_LAT-1];

        if (mode_d) begin
            // Refill: read memory, write cache.
            if (rd_issue_s) begin
                mem_addr_d = base_d + MEM_ADDR_W'(rd_k_d);
            end else begin
                mem_addr_d = {MEM_ADDR_W{1'b0}};
            end
            if (wr_valid_s) begin
                cache_addr_d = {index_d, wr_k_s};
                cache_we_d   = 1'b1;
            end else begin
                cache_addr_d = {CA_W{1'b0}};
                cache_we_d   = 1'b0;
            end
        end else begin
            // Writeback: read cache, write memory.
            if (rd_issue_s) begin
                cache_addr_d = {index_d, rd_k_d};
            end else begin
                cache_addr_d = {CA_W{1'b0}};
            end
            if (wr_valid_s) begin
                mem_addr_d = base_d + MEM_ADDR_W'(wr_k_s);
                mem_we_d   = 1'b1;
            end else begin
                mem_addr_d = {MEM_ADDR_W{1'b0}};
                mem_we_d   = 1'b0;
            end
        end

        busy_d = (state_d == S_XFER) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State, pipeline and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            index_q      <= {INDEX_W{1'b0}};
            base_q       <= {MEM_ADDR_W{1'b0}};
            rd_k_q       <= {OFF_W{1'b0}};
            drain_q      <= {DCNT_W{1'b0}};
            pv_q         <= {RD_LAT{1'b0}};
            pk_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cache_addr_q <= {CA_W{1'b0}};
            cache_we_q   <= 1'b0;
            mem_addr_q   <= {MEM_ADDR_W{1'b0}};
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            index_q      <= index_d;
            base_q       <= base_d;
            rd_k_q       <= rd_k_d;
            drain_q      <= drain_d;
            pv_q         <= pv_d;
            pk_q         <= pk_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cache_addr_q <= cache_addr_d;
            cache_we_q   <= cache_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_cache_line_xfer.sv
// -----------------------------------------------------------------------------
// Testbench for cache_line_xfer. Three instances run side by side:
//   cfg[0]: 8 words, RD_LAT=1   cfg[1]: 8 words, RD_LAT=3   cfg[2]: 4 words, RD_LAT=2
// Each instance gets its own RAM models (data is a fixed hash of the address,
// delivered RD_LAT cycles after the address was presented) and is checked every
// cycle against a timing model: word k is read in cycle 1+k, written in cycle
// 1+k+RD_LAT, busy spans cycles 1..W+L, done is cycle W+L+1.
// -----------------------------------------------------------------------------
module tb_cache_line_xfer;

    typedef struct {
        logic        m;
        logic [31:0] a;
        int          ca0;
        int          ma0;
        int          dc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] cword(input logic [31:0] x);
        return (x * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] x);
        return (x * 32'h85EBCA6B) ^ 32'h0BADF00D;
    endfunction

    task automatic check(input string nm, input int g, input int n,
                         input logic [67:0] a, input logic [67:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cfg%0d cycle %0d: got %h want %h", nm, g, n, a, e);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W     = (g == 2) ? 4 : 8;
        localparam int L     = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam int DC    = (g == 0) ? 10 : ((g == 1) ? 12 : 7);
        localparam int OFF_W = $clog2(W);
        localparam int CA_W  = 6 + OFF_W;

        logic              rst, start, mode;
        logic [31:0]       line_addr;
        logic              busy, done, cache_we, mem_we;
        logic [CA_W-1:0]   cache_addr;
        logic [12:0]       mem_addr;
        logic [31:0]       cache_din, cache_dout, mem_din, mem_dout;
        logic              fin_r = 1'b0;

        logic [CA_W-1:0]   ca_hist [L];
        logic [12:0]       ma_hist [L];

        cache_line_xfer #(
            .WORDS_PER_LINE(W), .INDEX_W(6), .ADDR_W(32),
            .MEM_ADDR_W(13), .RD_LAT(L)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .mode(mode),
            .line_addr(line_addr), .busy(busy), .done(done),
            .cache_addr(cache_addr), .cache_we(cache_we),
            .cache_din(cache_din), .cache_dout(cache_dout),
            .mem_addr(mem_addr), .mem_we(mem_we),
            .mem_din(mem_din), .mem_dout(mem_dout)
        );

        // RAM read models: data for the address presented L cycles ago.
        always @(posedge clk) begin
            ca_hist[0] <= cache_addr;
            ma_hist[0] <= mem_addr;
            for (int i = 1; i < L; i++) begin
                ca_hist[i] <= ca_hist[i-1];
                ma_hist[i] <= ma_hist[i-1];
            end
        end
        assign cache_dout = cword(32'(ca_hist[L-1]));
        assign mem_dout   = mword(32'(ma_hist[L-1]));

        // One transfer: optional cycle-0 drive, then cycles 1..W+L+2 checked.
        task automatic run(input logic m, input logic [31:0] a, input logic hold,
                           input int rst_at, input logic skip0,
                           input logic m2, input logic [31:0] a2,
                           input int ca0, input int ma0, input int dc);
            int          idx, base, rk, wk;
            logic        rv, wv, be, de;
            logic [31:0] ca, ma, dd;
            logic [67:0] act_v, exp_v;
            if (!skip0) begin
                @(negedge clk);
                start = 1'b1; mode = m; line_addr = a;
            end
            idx  = int'((a >> (OFF_W + 2)) & 32'h3F);
            base = int'(((a >> (OFF_W + 2)) << OFF_W) & 32'h1FFF);
            for (int n = 1; n <= W + L + 2; n++) begin
                @(negedge clk);
                if (!hold) start = 1'b0;
                mode = m2; line_addr = a2;
                rk = n - 1;
                wk = n - 1 - L;
                rv = (rk >= 0) && (rk < W);
                wv = (wk >= 0) && (wk < W);
                ca = 32'h0; ma = 32'h0; dd = 32'h0;
                if (!m) begin
                    if (rv) ca = 32'(idx * W + rk);
                    if (wv) begin
                        ma = 32'((base + wk) & 32'h1FFF);
                        dd = cword(32'(idx * W + wk));
                    end
                end else begin
                    if (rv) ma = 32'((base + rk) & 32'h1FFF);
                    if (wv) begin
                        ca = 32'(idx * W + wk);
                        dd = mword(32'((base + wk) & 32'h1FFF));
                    end
                end
                be = (n <= W + L);
                de = (n == W + L + 1);
                exp_v = {be, de, m & wv, ~m & wv, ca[15:0], ma[15:0], dd};
                if (rst_at > 0 && n > rst_at) exp_v = 68'h0;
                act_v = {busy, done, cache_we, mem_we, 16'(cache_addr), 16'(mem_addr), 32'h0};
                if (exp_v[64]) act_v[31:0] = mem_din;
                else if (exp_v[65]) act_v[31:0] = cache_din;
                check("cycle", g, n, act_v, exp_v);
                if (ca0 >= 0) begin
                    if (n == 1)
                        check("tbl_src", g, n, 68'(m ? 32'(mem_addr) : 32'(cache_addr)), 68'(m ? ma0 : ca0));
                    if (n == 1 + L)
                        check("tbl_dst", g, n, 68'(m ? 32'(cache_addr) : 32'(mem_addr)), 68'(m ? ca0 : ma0));
                    if (n == dc)
                        check("tbl_done", g, n, 68'({busy, done}), 68'(2'b01));
                end
                if (n == rst_at) rst = 1'b1;
                if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
            end
        endtask

        initial begin
            vec_t        tbl [4];
            logic        rm, rm2;
            logic [31:0] ra, ra2;
            rst = 1'b1; start = 1'b0; mode = 1'b0; line_addr = 32'h0;
            repeat (3) @(negedge clk);
            check("reset", g, 0,
                  {busy, done, cache_we, mem_we, 16'(cache_addr), 16'(mem_addr), 32'h0}, 68'h0);
            rst = 1'b0;

            tbl[0] = '{1'b0, 32'h0000_1A40, 32'h90, 32'h690, DC};
            tbl[1] = '{1'b1, 32'h0000_1A40, 32'h90, 32'h690, DC};
            tbl[2] = '{1'b0, 32'hFFFF_FFE0, (W == 8) ? 32'h1F8 : 32'hF8, 32'h1FF8, DC};
            tbl[3] = '{1'b1, 32'hFFFF_FFFC, (W == 8) ? 32'h1F8 : 32'hFC,
                       (W == 8) ? 32'h1FF8 : 32'h1FFC, DC};
            for (int t = 0; t < 4; t++)
                run(tbl[t].m, tbl[t].a, 1'b0, 0, 1'b0, tbl[t].m, tbl[t].a,
                    tbl[t].ca0, tbl[t].ma0, tbl[t].dc);

            // start held high; mode/addr change while busy, picked up next IDLE
            run(1'b0, 32'h0000_1A40, 1'b1, 0, 1'b0, 1'b1, 32'h0000_2B80, -1, -1, -1);
            run(1'b1, 32'h0000_2B80, 1'b0, 0, 1'b1, 1'b0, 32'h0, -1, -1, -1);

            // reset in cycle 5 of a writeback, then a fresh transfer
            run(1'b0, 32'h0000_1A40, 1'b0, 5, 1'b0, 1'b0, 32'h0000_1A40, -1, -1, -1);
            run(1'b1, 32'h0000_1A40, 1'b0, 0, 1'b0, 1'b1, 32'h0000_1A40, 32'h90, 32'h690, DC);

            // random transfers with random input noise while busy
            repeat (20) begin
                rm  = 1'($urandom_range(0, 1));
                ra  = $urandom;
                rm2 = 1'($urandom_range(0, 1));
                ra2 = $urandom;
                run(rm, ra, 1'b0, 0, 1'b0, rm2, ra2, -1, -1, -1);
            end
            fin_r = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (c < 20000 && !(cfg[0].fin_r && cfg[1].fin_r && cfg[2].fin_r)) begin
            @(posedge clk);
            c++;
        end
        n_tests++;
        if (!(cfg[0].fin_r && cfg[1].fin_r && cfg[2].fin_r)) begin
            n_fail++;
            $display("FAIL timeout: got unfinished after %0d cycles, want all configs finished", c);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_xfer.md
# cache_line_xfer

Parametrised cache-line transfer engine between the data cache array and main memory. It runs in two modes: writeback (cache to memory, for dirty-line eviction) and refill (memory to cache, for a miss). It sits between the cache controller FSM and the two synchronous RAMs. It streams one word per cycle and tolerates a configurable RAM read latency.

## Interface
- WORDS_PER_LINE, 8, words per line; power of 2, ≥2; OFF_W = log2(WORDS_PER_LINE)
- INDEX_W, 6, cache set-index bits
- ADDR_W, 32, CPU byte-address width
- MEM_ADDR_W, 13, main-memory word-address width
- RD_LAT, 1, read latency of both RAMs in cycles, 1..4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = writeback (cache→mem), 1 = refill (mem→cache)
- line_addr  in  ADDR_W  CPU byte address of line (word-offset and byte bits ignored)
- busy  out  1  high in XFER and DRAIN
- done  out  1  one-cycle pulse after final write
- cache_addr  out  INDEX_W+OFF_W  cache word address {index, word}
- cache_we  out  1  cache write enable (refill only)
- cache_din  out  32  equals mem_dout (combinational)
- cache_dout  in  32  cache read data
- mem_addr  out  MEM_ADDR_W  main-memory word address
- mem_we  out  1  memory write enable (writeback only)
- mem_din  out  32  equals cache_dout (combinational)
- mem_dout  in  32  memory read data

## Operation
- States: IDLE, XFER, DRAIN, DONE.
  - IDLE→XFER on start. mode and line_addr are latched at that edge.
  - XFER→DRAIN after WORDS_PER_LINE read issues.
  - DRAIN→DONE after RD_LAT cycles.
  - DONE→IDLE unconditionally.
- Address fields:
  - index = line_addr[OFF_W+2+INDEX_W-1 : OFF_W+2].
  - tag-line = line_addr[ADDR_W-1 : OFF_W+2].
- Word k (k = 0..WORDS_PER_LINE-1) addressing:
  - Cache address = {index, k}.
  - Memory address = low MEM_ADDR_W bits of ({tag-line, OFF_W'b0} + k). Upper bits are silently truncated.
- Source/destination by mode:
  - Writeback: source = cache, destination = memory.
  - Refill: source = memory, destination = cache.
- Read path: one source read is issued per XFER cycle, in ascending k.
- Write path:
  - A valid/offset shift pipeline of depth RD_LAT carries k to the write stage.
  - Destination write of word k occurs exactly RD_LAT cycles after read k is issued.
  - During that cycle the destination address is k and the data is the source dout.
- Output registration:
  - All outputs except cache_din/mem_din are registered.
  - The address of the memory not currently read or written holds 0.
  - The destination write enable is high only in write cycles.
  - The source memory's write enable is never asserted.
- start while busy or in DONE is ignored. No queueing.
- Reset values: busy=0, done=0, cache_we=0, mem_we=0, cache_addr=0, mem_addr=0. The pipeline is cleared and state = IDLE.
- rst mid-transfer:
  - All outputs take reset values in the next cycle.
  - Pending writes are dropped and done is not pulsed.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. Cycle n is the cycle after edge n.
- Reads of word k: source address valid in cycle 1+k.
- Writes of word k: destination we=1 in cycle 1+k+RD_LAT.
- busy = 1 in cycles 1 .. WORDS_PER_LINE+RD_LAT.
- done = 1 in cycle WORDS_PER_LINE+RD_LAT+1 only. busy = 0 in that cycle.
- Earliest next start is sampled in cycle WORDS_PER_LINE+RD_LAT+2. Back-to-back throughput is WORDS_PER_LINE+RD_LAT+2 cycles per line.
- Defaults (8 words, RD_LAT=1): reads in cycles 1–8, writes in cycles 2–9, done in cycle 10.
- The destination write enable is continuous: WORDS_PER_LINE consecutive cycles with no bubbles.

## Test plan
- Writeback, defaults, line_addr=0x0000_1A40 (index 0x12, tag-line 0xD2):
  - cache_addr 0x90..0x97 in cycles 1–8.
  - mem_we=1 and mem_addr 0x690..0x697 in cycles 2–9.
  - mem_din matches the preloaded cache words.
  - done only in cycle 10.
- Refill, RD_LAT=3, same address:
  - mem_addr 0x690..0x697 in cycles 1–8.
  - cache_we=1 with cache_addr 0x90..0x97 in cycles 4–11.
  - mem_we never asserted.
  - done in cycle 12.
- Truncation and wrap:
  - line_addr=0xFFFF_FFE0 → index 0x3F, cache_addr 0x1F8..0x1FF.
  - mem_addr 0x1FF8..0x1FFF (MEM_ADDR_W=13).
  - Low 5 address bits ignored (0xFFFF_FFFC gives the same addresses).
- start held high across the whole transfer:
  - Exactly one transfer per IDLE entry.
  - A second transfer begins only after start is sampled in IDLE (cycle 11 onward for defaults).
  - mode/line_addr changes during busy have no effect.
- rst asserted in cycle 5 of a writeback:
  - Cycle 6 shows all outputs 0 and busy=0.
  - No done pulse.
  - A fresh start afterwards completes normally.
- WORDS_PER_LINE=4, RD_LAT=2 refill: 4 writes in cycles 3–6, done in cycle 7.
